// File: rtl/frame_byte_reader.sv
// Streams a byte region out of the even/odd data-memory banks
// onto a valid/ready byte stream through a small credit-checked FIFO.
module frame_byte_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_even,
  output logic                  mem_rd_odd,
  output logic [ADDR_WIDTH-2:0] mem_addr,
  input  logic [7:0]            mem_data_even,
  input  logic [7:0]            mem_data_odd,
  output logic [7:0]            pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_READ, S_DRAIN, S_FINISH
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [LEN_WIDTH-1:0]  r_issue_left;
  logic [LEN_WIDTH-1:0]  r_deliver_left;
  logic                  r_inflight;
  logic                  r_lane;
  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr;
  logic [PW-1:0]         r_rd;
  logic [CW-1:0]         r_count;
  logic [CW:0]           w_occ;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic [7:0]            w_push_data;

  // Reads in flight count against FIFO space so a push never overflows.
  assign w_occ       = {1'b0, r_count} + (CW+1)'(r_inflight);
  assign w_issue     = (r_state == S_READ) && (r_issue_left != '0)
                       && (w_occ < (CW+1)'(FIFO_DEPTH));
  assign w_push      = r_inflight;
  assign w_push_data = r_lane ? mem_data_odd : mem_data_even;
  assign pix_valid   = (r_count != '0);
  assign pix_data    = pix_valid ? r_mem[r_rd] : 8'h00;
  assign w_pop       = pix_valid && pix_ready;
  assign mem_addr    = r_ptr[ADDR_WIDTH-1:1];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (start)
          w_next = (length != '0) ? S_READ : S_FINISH;
      S_READ:
        if (w_issue && r_issue_left == LEN_WIDTH'(1))
          w_next = S_DRAIN;
      S_DRAIN:
        if (w_pop && r_deliver_left == LEN_WIDTH'(1))
          w_next = S_FINISH;
      S_FINISH:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state == S_READ) || (r_state == S_DRAIN);
    done        = (r_state == S_FINISH);
    mem_rd_even = w_issue && !r_ptr[0];
    mem_rd_odd  = w_issue &&  r_ptr[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr          <= '0;
      r_issue_left   <= '0;
      r_deliver_left <= '0;
      r_inflight     <= 1'b0;
      r_lane         <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_lane <= r_ptr[0];
      if (r_state == S_IDLE && start) begin
        r_ptr          <= base_addr;
        r_issue_left   <= length;
        r_deliver_left <= length;
      end
      if (w_issue) begin
        r_ptr        <= r_ptr + ADDR_WIDTH'(1);
        r_issue_left <= r_issue_left - LEN_WIDTH'(1);
      end
      if (w_pop)
        r_deliver_left <= r_deliver_left - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_push_data;
  end

endmodule

// File: tb/tb_frame_byte_reader.sv
// Directed bench for frame_byte_reader with a two-bank memory model;
// byte at address a holds (a + 10) mod 256.
module tb_frame_byte_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [16:0] length;
  logic        busy;
  logic        done;
  logic        mem_rd_even;
  logic        mem_rd_odd;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data_even;
  logic [7:0]  mem_data_odd;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;

  frame_byte_reader dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .length(length),
    .busy(busy), .done(done),
    .mem_rd_even(mem_rd_even), .mem_rd_odd(mem_rd_odd),
    .mem_addr(mem_addr),
    .mem_data_even(mem_data_even), .mem_data_odd(mem_data_odd),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] ev [32768];
  logic [7:0] od [32768];

  always @(posedge clk) begin
    if (mem_rd_even) mem_data_even <= ev[mem_addr];
    if (mem_rd_odd)  mem_data_odd  <= od[mem_addr];
  end

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] got_q [$];
  int addr_q [$];
  int lane_q [$];
  int reads, both_cnt, done_cnt, stall_reads, held_bad;
  int busy_done, first_cyc, done_cyc;

  typedef struct {
    logic [15:0] base;
    logic [16:0] len;
    int          stall;
    int          exp_first;
    int          exp_last;
    int          exp_done;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic run_job(input logic [15:0] b, input logic [16:0] l,
                         input int stall);
    int cyc;
    logic [7:0] held;
    got_q.delete(); addr_q.delete(); lane_q.delete();
    reads = 0; both_cnt = 0; done_cnt = 0; stall_reads = 0;
    held_bad = 0; busy_done = 0; first_cyc = -1; done_cyc = -1;
    held = 8'h00;
    @(negedge clk);
    base_addr = b; length = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 300) begin
      pix_ready = (cyc <= stall) ? 1'b0 : 1'b1;
      if (mem_rd_even || mem_rd_odd) begin
        reads++;
        addr_q.push_back(int'(mem_addr));
        lane_q.push_back(mem_rd_odd ? 1 : 0);
        if (cyc <= stall) stall_reads++;
      end
      if (mem_rd_even && mem_rd_odd) both_cnt++;
      if (pix_valid && first_cyc < 0) begin
        first_cyc = cyc;
        held = pix_data;
      end
      if (cyc <= stall && pix_valid && pix_data != held) held_bad++;
      if (pix_valid && pix_ready) got_q.push_back(pix_data);
      if (done) begin
        done_cnt++;
        if (busy) busy_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_job(input vec_t v, input string tag);
    logic [7:0] e;
    run_job(v.base, v.len, v.stall);
    chk({tag, " bytes"}, got_q.size(), int'(v.len));
    for (int i = 0; i < got_q.size(); i++) begin
      e = 8'(int'(v.base) + i + 10);
      chk({tag, " byte"}, int'(got_q[i]), int'(e));
    end
    if (got_q.size() > 0) begin
      chk({tag, " first"}, int'(got_q[0]), v.exp_first);
      chk({tag, " last"}, int'(got_q[got_q.size()-1]), v.exp_last);
    end
    chk({tag, " reads"}, reads, int'(v.len));
    chk({tag, " both"}, both_cnt, 0);
    chk({tag, " done_cnt"}, done_cnt, 1);
    chk({tag, " busy_in_done"}, busy_done, 0);
    chk({tag, " first_valid"}, first_cyc, 3);
    if (v.exp_done != 0) chk({tag, " done_cyc"}, done_cyc, v.exp_done);
    if (v.stall >= 10) begin
      chk({tag, " stall_reads"}, stall_reads, 4);
      chk({tag, " held"}, held_bad, 0);
    end
  endtask

  initial begin
    int n;
    int rd_seen;
    for (int w = 0; w < 32768; w++) begin
      ev[w] = 8'(2 * w + 10);
      od[w] = 8'(2 * w + 11);
    end
    vecs[0] = '{16'd0,     17'd8, 0,  10, 17,  11};
    vecs[1] = '{16'd3,     17'd3, 0,  13, 15,  6};
    vecs[2] = '{16'd0,     17'd8, 10, 10, 17,  19};
    vecs[3] = '{16'hFFFF,  17'd2, 0,  9,  10,  5};
    vecs[4] = '{16'd5,     17'd7, 3,  15, 21,  0};
    vecs[5] = '{16'd100,   17'd1, 0,  110, 110, 4};

    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    pix_ready = 1'b1;
    mem_data_even = '0; mem_data_odd = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst rd", int'(mem_rd_even | mem_rd_odd), 0);
    chk("rst valid", int'(pix_valid), 0);
    chk("rst data", int'(pix_data), 0);
    chk("rst addr", int'(mem_addr), 0);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) check_job(vecs[k], $sformatf("vec%0d", k));

    // Odd base: lane and word address order
    run_job(16'd3, 17'd3, 0);
    chk("b3 nreads", addr_q.size(), 3);
    if (addr_q.size() == 3) begin
      chk("b3 addr0", addr_q[0], 1);
      chk("b3 addr1", addr_q[1], 2);
      chk("b3 addr2", addr_q[2], 2);
      chk("b3 lane0", lane_q[0], 1);
      chk("b3 lane1", lane_q[1], 0);
      chk("b3 lane2", lane_q[2], 1);
    end

    // Wrap addresses
    run_job(16'hFFFF, 17'd2, 0);
    chk("wrap nreads", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      chk("wrap addr0", addr_q[0], 32767);
      chk("wrap addr1", addr_q[1], 0);
      chk("wrap lane0", lane_q[0], 1);
      chk("wrap lane1", lane_q[1], 0);
    end

    // Zero length
    @(negedge clk);
    base_addr = 16'd0; length = 17'd0; start = 1'b1;
    rd_seen = 0;
    @(negedge clk);
    start = 1'b0;
    chk("len0 done", int'(done), 1);
    chk("len0 busy", int'(busy), 0);
    if (mem_rd_even || mem_rd_odd) rd_seen++;
    @(negedge clk);
    chk("len0 done off", int'(done), 0);
    chk("len0 busy2", int'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      if (mem_rd_even || mem_rd_odd || busy) rd_seen++;
      @(negedge clk);
    end
    chk("len0 quiet", rd_seen, 0);

    // Reset mid-transfer
    base_addr = 16'd0; length = 17'd8; start = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (pix_valid && pix_ready) n++;
      if (n < 3) @(negedge clk);
    end
    chk("abort xfers", n, 3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort valid", int'(pix_valid), 0);
    chk("abort done", int'(done), 0);
    rd_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || mem_rd_even || mem_rd_odd || pix_valid) rd_seen++;
      @(negedge clk);
    end
    chk("abort quiet", rd_seen, 0);
    check_job(vecs[0], "rerun");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/frame_byte_reader.md
Name: frame_byte_reader

Overview:
Read-side master for the split even/odd byte-banked data memory that the processor writes. On a start command it streams a contiguous byte region, from base_addr for length bytes, out of the two 8-bit banks, in ascending byte order. Bytes leave on a valid/ready stream toward the display or host-dump path. It uses the banks' second read port, so processor memory traffic is untouched.

Parameters:
ADDR_WIDTH, 16, byte-address width; bank word address is ADDR_WIDTH-1 bits.
LEN_WIDTH, 17, width of length (allows a full 2^16-byte region).
FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.

Ports:
clk  input  1  single clock, rising-edge.
reset  input  1  synchronous, active-high.
start  input  1  one-cycle command strobe; sampled only in IDLE.
base_addr  input  ADDR_WIDTH  first byte address; captured on accepted start.
length  input  LEN_WIDTH  byte count; captured on accepted start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse when the last byte has been accepted downstream.
mem_rd_even  output  1  read strobe, even bank.
mem_rd_odd  output  1  read strobe, odd bank.
mem_addr  output  ADDR_WIDTH-1  bank word address, equal to byte_ptr>>1; shared by both banks.
mem_data_even  input  8  even-bank read data, valid one cycle after mem_rd_even.
mem_data_odd  input  8  odd-bank read data, valid one cycle after mem_rd_odd.
pix_data  output  8  stream byte (FIFO head).
pix_valid  output  1  FIFO not empty.
pix_ready  input  1  downstream accept; a transfer happens when pix_valid and pix_ready are both high.

Behaviour:
- Clocking and reset: one clock; reset is synchronous, active-high.
- Reset values: every output is 0. State is IDLE, FIFO is empty, counters are 0. Reset mid-transfer aborts: in-flight read data is discarded, no done pulse is issued, busy=0 on the next cycle.
- IDLE:
  - start=1 with length>0: latch byte_ptr=base_addr, issue_left=length, deliver_left=length, go to READ.
  - start=1 with length=0: go to FINISH; no memory reads occur.
- READ, issue rule: issue one byte read per cycle when issue_left>0 and (fifo_count + inflight) < FIFO_DEPTH.
  - byte_ptr[0]=0 asserts mem_rd_even; byte_ptr[0]=1 asserts mem_rd_odd. Never both.
  - On issue: byte_ptr += 1 (wraps modulo 2^ADDR_WIDTH), issue_left -= 1.
- READ, read return:
  - Registered inflight flag and lane bit; read latency is exactly 1 cycle.
  - The next cycle pushes mem_data_even or mem_data_odd according to the registered lane.
  - The credit check guarantees a push never meets a full FIFO.
- FIFO:
  - Push and pop in the same cycle are both legal; occupancy is unchanged.
  - Pop when pix_valid and pix_ready; deliver_left -= 1 per pop.
  - pix_data is stable while pix_valid=1 and pix_ready=0.
- Transitions:
  - READ goes to DRAIN when issue_left reaches 0.
  - DRAIN goes to FINISH on the pop that makes deliver_left 0.
  - FINISH asserts done for one cycle, then returns to IDLE.
  - busy=1 in READ and DRAIN. busy=0 in IDLE and in FINISH.
- start outside IDLE is ignored.
- Throughput: with pix_ready held high, one byte per cycle after a 2-cycle startup. The first pix_valid appears 2 cycles after the accepted start edge.
- Odd base_addr is legal. The first read goes to the odd bank at word base_addr>>1, then the even bank at word (base_addr>>1)+1.

Test Plan:
- Preload even[0..3]={10,12,14,16}, odd[0..3]={11,13,15,17}; start base=0 len=8, pix_ready=1 -> stream 10,11,…,17 on consecutive cycles; done pulses exactly once, one cycle after the 8th transfer.
- base=3, len=3 -> stream odd[1], even[2], odd[2] = 13,14,15; reads alternate lanes with mem_addr 1, 2, 2.
- len=8 with pix_ready low for 10 cycles after start -> at most FIFO_DEPTH=4 reads issued, pix_data holds 10; after release all 8 bytes arrive in order with no loss or duplication.
- start with len=0 -> done pulses 1 cycle later; mem_rd_even/mem_rd_odd never asserted; busy stays 0.
- base=0xFFFF, len=2 -> reads odd word 0x7FFF then even word 0x0000 (wrap); 2 bytes delivered.
- reset asserted after 3 transfers of a len=8 job -> next cycle busy=0, pix_valid=0, no done pulse; a new start then behaves exactly as in the first scenario.
